// File: rtl/reorder_rd_ctrl.sv
// ---------------------------------------------------------------------------
// reorder_rd_ctrl
//   Read-side controller for the FFT re-order memory. Once the write side has
//   filled a bank in natural order, this block reads that bank back in
//   digit-reversed order. It ping-pongs between two banks and emits output
//   framing that lines up with the memory read latency.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   wr_done    one-cycle pulse: a frame is complete in the bank not being read
//   RDMA       registered read address, digit_reverse(cnt)
//   rd_en      registered memory read enable
//   rd_bank    bank currently being read (0/1)
//   out_valid  memory read data valid (rd_en delayed by RD_LAT)
//   out_sop    first sample of a frame, coincident with out_valid
//   out_eop    last sample of a frame, coincident with out_valid
//   busy       controller is not idle
//   overrun    sticky: a frame request was dropped
// ---------------------------------------------------------------------------
module reorder_rd_ctrl #(
  parameter int DIGIT_WIDTH = 3,
  parameter int NUM_DIGITS  = 3,
  parameter int RD_LAT      = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_done,
  output logic [DIGIT_WIDTH*NUM_DIGITS-1:0] RDMA,
  output logic                              rd_en,
  output logic                              rd_bank,
  output logic                              out_valid,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic                              busy,
  output logic                              overrun
);

  localparam int AW = DIGIT_WIDTH * NUM_DIGITS;
  localparam int FW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0] CNT_LAST   = '1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [FW-1:0]   flush_cnt, flush_cnt_nxt;
  logic            pending, pending_nxt;
  logic            overrun_nxt;
  logic            rd_en_nxt;
  logic            bank_nxt;
  logic            start;

  // Digit k of the natural index becomes digit NUM_DIGITS-1-k of the
  // address; bit order inside a digit is kept.
  function automatic logic [AW-1:0] digit_reverse(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      r[(NUM_DIGITS-1-k)*DIGIT_WIDTH +: DIGIT_WIDTH] = a[k*DIGIT_WIDTH +: DIGIT_WIDTH];
    end
    return r;
  endfunction

  // Next-state logic. A new frame starts from IDLE on wr_done, or without
  // a gap at the end of a frame / end of the drain when a request is queued.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_nxt     = state;
    cnt_nxt       = cnt;
    flush_cnt_nxt = flush_cnt;
    pending_nxt   = pending;
    overrun_nxt   = overrun;
    rd_en_nxt     = 1'b0;
    bank_nxt      = rd_bank;
    start         = 1'b0;

    unique case (state)
      IDLE: begin
        if (wr_done) start = 1'b1;
      end
      READ: begin
        rd_en_nxt = 1'b1;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          if (pending || wr_done) begin
            start = 1'b1;
          end else begin
            state_nxt     = FLUSH;
            rd_en_nxt     = 1'b0;
            cnt_nxt       = '0;
            flush_cnt_nxt = '0;
          end
        end
      end
      FLUSH: begin
        flush_cnt_nxt = flush_cnt + 1'b1;
        if (flush_cnt == FLUSH_LAST) begin
          if (pending || wr_done) start = 1'b1;
          else                    state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start) begin
      state_nxt   = READ;
      cnt_nxt     = '0;
      rd_en_nxt   = 1'b1;
      bank_nxt    = ~rd_bank;
      // A queued request is consumed here; a wr_done in this same cycle
      // re-arms it (only possible when pending was the trigger).
      pending_nxt = pending && wr_done;
    end else if (wr_done && (state != IDLE)) begin
      if (pending) overrun_nxt = 1'b1;
      else         pending_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      flush_cnt <= '0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
      rd_en     <= 1'b0;
      RDMA      <= '0;
      rd_bank   <= 1'b1;   // first toggle selects bank 0
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      flush_cnt <= flush_cnt_nxt;
      pending   <= pending_nxt;
      overrun   <= overrun_nxt;
      rd_en     <= rd_en_nxt;
      RDMA      <= digit_reverse(cnt_nxt);
      rd_bank   <= bank_nxt;
    end
  end

  // Framing pipeline: rd_en and its frame markers travel RD_LAT stages so
  // they line up with the memory data. Stage RD_LAT-1 drives the outputs.
  logic [RD_LAT-1:0] valid_sr, sop_sr, eop_sr;

  // NOTE: the framing shift registers are reset along with the control
  // state so a reset mid-frame can never emit a stale sop/eop afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      sop_sr   <= '0;
      eop_sr   <= '0;
    end else begin
      valid_sr[0] <= rd_en;
      sop_sr[0]   <= rd_en && (cnt == '0);
      eop_sr[0]   <= rd_en && (cnt == CNT_LAST);
      for (int i = 1; i < RD_LAT; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        sop_sr[i]   <= sop_sr[i-1];
        eop_sr[i]   <= eop_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[RD_LAT-1];
  assign out_sop   = sop_sr[RD_LAT-1];
  assign out_eop   = eop_sr[RD_LAT-1];
  assign busy      = (state != IDLE);

endmodule
